// File: rtl/sg_frame_sequencer.sv
// sg_frame_sequencer
//   Runs one Savitzky-Golay smoothing pass over a frame held in sample RAM.
//   It keeps a sliding window of WINDOW_SIZE samples and offers each full window
//   to the fit engine over a valid/ready handshake. It writes each fitted centre
//   value to result RAM, and repeats the first and last fits into the H edge
//   positions at each end of the frame.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      begin a pass (only seen when idle) / cancel a pass
//   busy, done        pass in progress / one-cycle end-of-pass pulse
//   smp_rd_*          sample RAM read port (data returns one cycle after en)
//   fit_valid/ready   window handshake; fit_window slot k = sample c-H+k
//   fit_res_valid/res fitted centre value returned by the engine
//   res_wr_*          result RAM write port
//   fit_count         windows accepted by the engine in this (or the last) pass
module sg_frame_sequencer #(
  parameter int DATA_W      = 16,
  parameter int RES_W       = 24,
  parameter int ADDR_W      = 10,
  parameter int WINDOW_SIZE = 7,
  parameter int FRAME_LEN   = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          smp_rd_en,
  output logic [ADDR_W-1:0]             smp_rd_addr,
  input  logic [DATA_W-1:0]             smp_rd_data,
  output logic                          fit_valid,
  input  logic                          fit_ready,
  output logic [WINDOW_SIZE*DATA_W-1:0] fit_window,
  input  logic                          fit_res_valid,
  input  logic [RES_W-1:0]              fit_res,
  output logic                          res_wr_en,
  output logic [ADDR_W-1:0]             res_wr_addr,
  output logic [RES_W-1:0]              res_wr_data,
  output logic [ADDR_W-1:0]             fit_count
);

  localparam int H     = WINDOW_SIZE / 2;
  localparam int CNT_W = $clog2(WINDOW_SIZE + 1);

  localparam logic [ADDR_W-1:0] C_FIRST   = ADDR_W'(H);
  localparam logic [ADDR_W-1:0] C_LAST    = ADDR_W'(FRAME_LEN - H - 1);
  localparam logic [ADDR_W-1:0] TAIL_BASE = ADDR_W'(FRAME_LEN - H);

  typedef enum logic [3:0] {
    S_IDLE, S_PRIME, S_ISSUE, S_WAIT, S_WRITE,
    S_HEAD, S_SHIFT, S_LOAD, S_TAIL, S_DONE
  } state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  c, c_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [ADDR_W-1:0]  fit_count_next;
  logic [RES_W-1:0]   res_q, res_next;
  logic               shift_in;
  logic [DATA_W-1:0]  win [WINDOW_SIZE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      c         <= '0;
      cnt       <= '0;
      fit_count <= '0;
      res_q     <= '0;
    end else begin
      state     <= state_next;
      c         <= c_next;
      cnt       <= cnt_next;
      fit_count <= fit_count_next;
      res_q     <= res_next;
    end
  end

  // New samples enter at the top slot so slot 0 always holds the oldest sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < WINDOW_SIZE; k++) win[k] <= '0;
    end else if (shift_in) begin
      for (int k = 0; k < WINDOW_SIZE - 1; k++) win[k] <= win[k+1];
      win[WINDOW_SIZE-1] <= smp_rd_data;
    end
  end

  always_comb begin
    fit_window = '0;
    for (int k = 0; k < WINDOW_SIZE; k++) fit_window[k*DATA_W +: DATA_W] = win[k];
  end

  // cnt is shared: read index while priming, edge-write index in HEAD/TAIL.
  // abort overrides everything, including strobes already in progress this cycle.
  always_comb begin
    state_next     = state;
    c_next         = c;
    cnt_next       = cnt;
    fit_count_next = fit_count;
    res_next       = res_q;
    shift_in       = 1'b0;
    busy           = (state != S_IDLE) && (state != S_DONE);
    done           = 1'b0;
    smp_rd_en      = 1'b0;
    smp_rd_addr    = '0;
    fit_valid      = 1'b0;
    res_wr_en      = 1'b0;
    res_wr_addr    = '0;
    res_wr_data    = '0;

    if (abort && state != S_IDLE) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_next     = S_PRIME;
            fit_count_next = '0;
            c_next         = C_FIRST;
            cnt_next       = '0;
          end
        end
        // Data for read cnt-1 is on the bus while read cnt is issued.
        S_PRIME: begin
          smp_rd_en   = (cnt < CNT_W'(WINDOW_SIZE));
          smp_rd_addr = ADDR_W'(cnt);
          shift_in    = (cnt != '0);
          if (cnt == CNT_W'(WINDOW_SIZE)) begin
            state_next = S_ISSUE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        S_ISSUE: begin
          fit_valid = 1'b1;
          if (fit_ready) begin
            fit_count_next = fit_count + ADDR_W'(1);
            state_next     = S_WAIT;
          end
        end
        S_WAIT: begin
          if (fit_res_valid) begin
            res_next   = fit_res;
            state_next = S_WRITE;
          end
        end
        S_WRITE: begin
          res_wr_en   = 1'b1;
          res_wr_addr = c;
          res_wr_data = res_q;
          cnt_next    = '0;
          if (c == C_FIRST)     state_next = S_HEAD;
          else if (c == C_LAST) state_next = S_TAIL;
          else                  state_next = S_SHIFT;
        end
        S_HEAD: begin
          res_wr_en   = 1'b1;
          res_wr_addr = ADDR_W'(cnt);
          res_wr_data = res_q;
          cnt_next    = cnt + CNT_W'(1);
          if (cnt == CNT_W'(H - 1)) begin
            cnt_next   = '0;
            state_next = (c == C_LAST) ? S_TAIL : S_SHIFT;
          end
        end
        S_SHIFT: begin
          smp_rd_en   = 1'b1;
          smp_rd_addr = c + ADDR_W'(H + 1);
          c_next      = c + ADDR_W'(1);
          state_next  = S_LOAD;
        end
        S_LOAD: begin
          shift_in   = 1'b1;
          state_next = S_ISSUE;
        end
        S_TAIL: begin
          res_wr_en   = 1'b1;
          res_wr_addr = TAIL_BASE + ADDR_W'(cnt);
          res_wr_data = res_q;
          cnt_next    = cnt + CNT_W'(1);
          if (cnt == CNT_W'(H - 1)) begin
            cnt_next   = '0;
            state_next = S_DONE;
          end
        end
        S_DONE: begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sg_frame_sequencer.sv
// tb_sg_frame_sequencer
//   Drives a 16-sample frame (instance a) and a 7-sample frame (instance b)
//   through sg_frame_sequencer, with a sample RAM, a fit engine and a result
//   RAM modelled here, and compares everything against an array-based model.
module tb_sg_frame_sequencer;

  localparam int DW  = 16;
  localparam int RW  = 24;
  localparam int AW  = 10;
  localparam int WS  = 7;
  localparam int H   = WS / 2;
  localparam int LA  = 16;
  localparam int LB  = 7;
  localparam int AWB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance a
  logic              start = 1'b0, abort = 1'b0;
  logic              busy, done, smp_rd_en, fit_valid, res_wr_en;
  logic              fit_ready, fit_res_valid;
  logic [AW-1:0]     smp_rd_addr, res_wr_addr, fit_count;
  logic [DW-1:0]     smp_rd_data;
  logic [WS*DW-1:0]  fit_window;
  logic [RW-1:0]     fit_res, res_wr_data;

  // instance b
  logic              start_b = 1'b0, abort_b = 1'b0;
  logic              busy_b, done_b, smp_rd_en_b, fit_valid_b, res_wr_en_b;
  logic              fit_ready_b = 1'b1, fit_res_valid_b = 1'b0;
  logic [AWB-1:0]    smp_rd_addr_b, res_wr_addr_b, fit_count_b;
  logic [DW-1:0]     smp_rd_data_b;
  logic [WS*DW-1:0]  fit_window_b;
  logic [RW-1:0]     fit_res_b = '0, res_wr_data_b;

  sg_frame_sequencer #(.DATA_W(DW), .RES_W(RW), .ADDR_W(AW), .WINDOW_SIZE(WS), .FRAME_LEN(LA)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .smp_rd_en(smp_rd_en), .smp_rd_addr(smp_rd_addr), .smp_rd_data(smp_rd_data),
    .fit_valid(fit_valid), .fit_ready(fit_ready), .fit_window(fit_window),
    .fit_res_valid(fit_res_valid), .fit_res(fit_res),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
    .fit_count(fit_count));

  sg_frame_sequencer #(.DATA_W(DW), .RES_W(RW), .ADDR_W(AWB), .WINDOW_SIZE(WS), .FRAME_LEN(LB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
    .smp_rd_en(smp_rd_en_b), .smp_rd_addr(smp_rd_addr_b), .smp_rd_data(smp_rd_data_b),
    .fit_valid(fit_valid_b), .fit_ready(fit_ready_b), .fit_window(fit_window_b),
    .fit_res_valid(fit_res_valid_b), .fit_res(fit_res_b),
    .res_wr_en(res_wr_en_b), .res_wr_addr(res_wr_addr_b), .res_wr_data(res_wr_data_b),
    .fit_count(fit_count_b));

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] smp [LA];
  logic [RW-1:0] res_mem [LA];
  int            wr_cnt [LA];
  int            total_wr = 0, done_cnt = 0, hs_idx = 0;
  int            mode = 0;
  int            lat_fixed = 3;
  bit            rand_ready = 1'b0;
  int            stall_idx = -1, stall_left = 0;
  int            spurious_left = 0;
  bit            hold_prev = 1'b0;
  logic [WS*DW-1:0] hold_win;

  logic [RW-1:0] res_b_mem [LB];
  int            wr_b_cnt [LB];
  int            total_b = 0, done_b_cnt = 0;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic int fit_math(input int v [WS], input int m);
    int acc;
    acc = 0;
    if (m == 0) return 2 * v[H];
    for (int k = 0; k < WS; k++) acc += (k + 1) * v[k];
    return acc;
  endfunction

  function automatic logic [WS*DW-1:0] expect_win(input int ctr);
    logic [WS*DW-1:0] w;
    for (int k = 0; k < WS; k++) w[k*DW +: DW] = smp[ctr-H+k];
    return w;
  endfunction

  // Edge positions reuse the nearest interior fit.
  function automatic logic [RW-1:0] expect_res(input int a);
    int ctr;
    int v [WS];
    ctr = (a < H) ? H : ((a > LA-H-1) ? LA-H-1 : a);
    for (int k = 0; k < WS; k++) v[k] = int'($signed(smp[ctr-H+k]));
    return RW'(fit_math(v, mode));
  endfunction

  always @(posedge clk) smp_rd_data   <= (int'(smp_rd_addr) < LA) ? smp[smp_rd_addr] : 16'hDEAD;
  always @(posedge clk) smp_rd_data_b <= (int'(smp_rd_addr_b) < LB) ? DW'(smp_rd_addr_b) : 16'hDEAD;

  // Engine for instance a: variable latency, optional stray result pulses.
  initial begin
    logic [WS*DW-1:0] w;
    int v [WS];
    int l;
    bit hs;
    fit_res_valid = 1'b0;
    fit_res = '0;
    forever begin
      @(negedge clk);
      hs = 1'b0;
      if (fit_valid && spurious_left > 0) begin
        fit_res = 24'h5A5A5A;
        fit_res_valid = 1'b1;
        spurious_left--;
      end
      if (fit_valid && fit_ready) begin
        hs = 1'b1;
        w = fit_window;
      end
      @(posedge clk); #1;
      fit_res_valid = 1'b0;
      if (hs) begin
        l = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
        repeat (l - 1) begin @(posedge clk); #1; end
        for (int k = 0; k < WS; k++) v[k] = int'($signed(w[k*DW +: DW]));
        fit_res = RW'(fit_math(v, mode));
        fit_res_valid = 1'b1;
      end
    end
  end

  // fit_ready: optional stall of stall_left valid cycles on fit number stall_idx+1.
  initial begin
    fit_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && int'(fit_count) == stall_idx) begin
        fit_ready = 1'b0;
        if (fit_valid) stall_left--;
      end else begin
        fit_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Engine for instance b: latency 1, result = 2 * centre.
  initial begin
    logic [WS*DW-1:0] wb;
    forever begin
      @(negedge clk);
      if (fit_valid_b && fit_ready_b) begin
        wb = fit_window_b;
        @(posedge clk); #1;
        fit_res_b = RW'(2 * int'($signed(wb[H*DW +: DW])));
        fit_res_valid_b = 1'b1;
        @(posedge clk); #1;
        fit_res_valid_b = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (res_wr_en) begin
        total_wr++;
        if (int'(res_wr_addr) < LA) begin
          wr_cnt[res_wr_addr]++;
          res_mem[res_wr_addr] = res_wr_data;
        end else checkOutput("wr_addr_range", 128'(res_wr_addr), 128'(LA-1));
      end
      if (done) done_cnt++;
      if (hold_prev) begin
        checkOutput("hold_valid", 128'(fit_valid), 128'(1));
        checkOutput("hold_window", 128'(fit_window), 128'(hold_win));
      end
      if (fit_valid && fit_ready) begin
        if (H + hs_idx <= LA-H-1) checkOutput("hs_window", 128'(fit_window), 128'(expect_win(H + hs_idx)));
        else checkOutput("hs_extra", 128'(hs_idx), 128'(LA-2*H-1));
        hs_idx++;
      end
      hold_prev = fit_valid && !fit_ready;
      hold_win  = fit_window;
      if (res_wr_en_b) begin
        total_b++;
        if (int'(res_wr_addr_b) < LB) begin
          wr_b_cnt[res_wr_addr_b]++;
          res_b_mem[res_wr_addr_b] = res_wr_data_b;
        end
      end
      if (done_b) done_b_cnt++;
      if (fit_valid_b && fit_ready_b) begin
        for (int k = 0; k < WS; k++)
          checkOutput("b_window_slot", 128'(fit_window_b[k*DW +: DW]), 128'(k));
      end
    end
  end

  task automatic applyStimulus();
    total_wr = 0; done_cnt = 0; hs_idx = 0;
    for (int a = 0; a < LA; a++) begin wr_cnt[a] = 0; res_mem[a] = '0; end
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic waitDone();
    int i;
    i = 0;
    while (done_cnt == 0 && i < 3000) begin @(posedge clk); #1; i++; end
    checkOutput("done_seen", 128'(done_cnt > 0), 128'(1));
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic waitFitCount(input int n);
    int i;
    i = 0;
    while (int'(fit_count) != n && i < 3000) begin @(posedge clk); #1; i++; end
    checkOutput("fit_count_reached", 128'(fit_count), 128'(n));
  endtask

  task automatic checkPass();
    checkOutput("done_count", 128'(done_cnt), 128'(1));
    checkOutput("write_total", 128'(total_wr), 128'(LA));
    checkOutput("fit_count_end", 128'(fit_count), 128'(LA-2*H));
    checkOutput("busy_idle", 128'(busy), 128'(0));
    for (int a = 0; a < LA; a++) begin
      checkOutput($sformatf("wr_once[%0d]", a), 128'(wr_cnt[a]), 128'(1));
      checkOutput($sformatf("res[%0d]", a), 128'(res_mem[a]), 128'(expect_res(a)));
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},   128'(busy), 128'(0));
    checkOutput({tag, "_done"},   128'(done), 128'(0));
    checkOutput({tag, "_rd_en"},  128'(smp_rd_en), 128'(0));
    checkOutput({tag, "_valid"},  128'(fit_valid), 128'(0));
    checkOutput({tag, "_wr_en"},  128'(res_wr_en), 128'(0));
  endtask

  task automatic setIndexSamples();
    for (int i = 0; i < LA; i++) smp[i] = DW'(i);
    mode = 0; lat_fixed = 3; rand_ready = 1'b0;
  endtask

  initial begin
    int wr_at_abort;
    int i;
    // reset state
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    checkOutput("reset_fit_count", 128'(fit_count), 128'(0));
    checkOutput("reset_window", 128'(fit_window), 128'(0));
    checkOutput("reset_wr_addr", 128'(res_wr_addr), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] index ramp, fixed latency 3");
    setIndexSamples();
    applyStimulus();
    waitDone();
    checkPass();
    checkOutput("t1_res0",  128'(res_mem[0]),  128'(6));
    checkOutput("t1_res3",  128'(res_mem[3]),  128'(6));
    checkOutput("t1_res12", 128'(res_mem[12]), 128'(24));
    checkOutput("t1_res15", 128'(res_mem[15]), 128'(24));

    $display("[TB] ready held low on second fit");
    stall_idx = 1; stall_left = 5;
    applyStimulus();
    waitDone();
    checkPass();
    checkOutput("stall_consumed", 128'(stall_left), 128'(0));
    stall_idx = -1;

    $display("[TB] reset mid-pass then restart");
    applyStimulus();
    waitFitCount(4);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkIdleOutputs("midrst");
    checkOutput("midrst_fit_count", 128'(fit_count), 128'(0));
    checkOutput("midrst_window", 128'(fit_window), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    applyStimulus();
    waitDone();
    checkPass();

    $display("[TB] abort while waiting for sixth result");
    applyStimulus();
    waitFitCount(6);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wr_at_abort = total_wr;
    checkIdleOutputs("abort");
    repeat (30) begin @(posedge clk); #1; end
    checkOutput("abort_no_done", 128'(done_cnt), 128'(0));
    checkOutput("abort_no_more_writes", 128'(total_wr), 128'(wr_at_abort));
    checkOutput("abort_writes", 128'(total_wr), 128'(H + 5));
    checkOutput("abort_fit_count", 128'(fit_count), 128'(6));
    checkOutput("abort_busy", 128'(busy), 128'(0));

    $display("[TB] start during busy and stray results in ISSUE");
    spurious_left = 2;
    applyStimulus();
    waitFitCount(3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone();
    checkPass();
    checkOutput("stray_used", 128'(spurious_left), 128'(0));

    $display("[TB] frame length equals window size");
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    i = 0;
    while (done_b_cnt == 0 && i < 500) begin @(posedge clk); #1; i++; end
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("b_done_count", 128'(done_b_cnt), 128'(1));
    checkOutput("b_write_total", 128'(total_b), 128'(LB));
    checkOutput("b_fit_count", 128'(fit_count_b), 128'(1));
    for (int a = 0; a < LB; a++) begin
      checkOutput($sformatf("b_wr_once[%0d]", a), 128'(wr_b_cnt[a]), 128'(1));
      checkOutput($sformatf("b_res[%0d]", a), 128'(res_b_mem[a]), 128'(6));
    end

    $display("[TB] randomized passes");
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < LA; j++) smp[j] = DW'($urandom);
      mode = 1; lat_fixed = 0; rand_ready = 1'b1;
      spurious_left = int'($urandom_range(0, 2));
      applyStimulus();
      waitDone();
      checkPass();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
